// File: rtl/parallel_serial_tx.sv
// parallel_serial_tx
//   Parallel-in, serial-out transmitter. A WIDTH-bit word is accepted through
//   a valid/ready handshake and shifted out LSB first on sout, one bit per
//   clock. sout_valid frames every transmitted bit. done pulses during the
//   last bit of a frame. Back-to-back words stream with no idle gap.
//
//   Optional feature, enabled by defining PARALLEL_SERIAL_TX_PARITY_EN:
//   an even-parity bit is appended after the data bits. The frame then
//   lasts WIDTH+1 cycles, and done/load_ready move to the parity cycle.
//
//   Handshake: a word is taken on a rising clk edge where load_valid and
//   load_ready are both high. While load_valid is high and load_ready is low,
//   the source must hold din and load_valid steady. load_ready never depends
//   on load_valid.

module parallel_serial_tx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

`ifdef PARALLEL_SERIAL_TX_PARITY_EN
    localparam int FLEN = WIDTH + 1;
`else
    localparam int FLEN = WIDTH;
`endif

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             accept;

`ifdef PARALLEL_SERIAL_TX_PARITY_EN
    logic             par;
`endif

    // Last cycle of the current frame; the only SHIFT cycle a new word may load.
    assign last   = (state_q == SHIFT) && (cnt == CW'(FLEN - 1));
    assign accept = load_valid && load_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and frame outputs.
    always_comb begin
        state_d    = state_q;
        load_ready = 1'b0;
        sout       = 1'b0;
        sout_valid = 1'b0;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sout_valid = 1'b1;
                sout       = shreg[0];
`ifdef PARALLEL_SERIAL_TX_PARITY_EN
                // The extra cycle after the data bits carries the parity bit.
                if (cnt == CW'(WIDTH)) begin
                    sout = par;
                end
`endif
                done       = last;
                load_ready = last;
                if (last && !load_valid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Shift register, bit counter and parity; a new word overrides the shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
            cnt   <= '0;
`ifdef PARALLEL_SERIAL_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else if (accept) begin
            shreg <= din;
            cnt   <= '0;
`ifdef PARALLEL_SERIAL_TX_PARITY_EN
            par   <= ^din;
`endif
        end else if (state_q == SHIFT) begin
            shreg <= {1'b0, shreg[WIDTH-1:1]};
            // Clear at frame end instead of counting past the frame length.
            if (last) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_parallel_serial_tx.sv
// tb_parallel_serial_tx
//   Directed bench for parallel_serial_tx. Two instances: WIDTH=4 and WIDTH=8.
//   Expected serial bits are hand-computed and queued in exp_q, then popped
//   one per cycle. Parity expectations follow PARALLEL_SERIAL_TX_PARITY_EN.

module tb_parallel_serial_tx;

`ifdef PARALLEL_SERIAL_TX_PARITY_EN
    localparam int FL4 = 5;
    localparam int FL8 = 9;
`else
    localparam int FL4 = 4;
    localparam int FL8 = 8;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [3:0] din4;
    logic       lv4;
    logic       lr4;
    logic       so4;
    logic       sv4;
    logic       dn4;

    logic [7:0] din8;
    logic       lv8;
    logic       lr8;
    logic       so8;
    logic       sv8;
    logic       dn8;

    parallel_serial_tx #(.WIDTH(4)) u_dut4 (
        .clk        (clk),
        .rst        (rst),
        .din        (din4),
        .load_valid (lv4),
        .load_ready (lr4),
        .sout       (so4),
        .sout_valid (sv4),
        .done       (dn4)
    );

    parallel_serial_tx #(.WIDTH(8)) u_dut8 (
        .clk        (clk),
        .rst        (rst),
        .din        (din8),
        .load_valid (lv8),
        .load_ready (lr8),
        .sout       (so8),
        .sout_valid (sv8),
        .done       (dn8)
    );

    // ---------------- scoreboard ----------------
    int         checks = 0;
    int         errors = 0;
    logic [0:0] exp_q[$];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_bits4(input logic [3:0] w, input logic p);
        for (int i = 0; i < 4; i++) exp_q.push_back(w[i]);
`ifdef PARALLEL_SERIAL_TX_PARITY_EN
        exp_q.push_back(p);
`else
        if (p === 1'bx) exp_q.push_back(1'b0);
`endif
    endtask

    // Called in cycle 1 of a single WIDTH=4 frame; ends one cycle after it.
    task automatic check_frame4(input string tag);
        logic [0:0] b;
        for (int i = 0; i < FL4; i++) begin
            b = exp_q.pop_front();
            chk({tag, "_sout"}, {7'd0, so4}, {7'd0, b});
            chk({tag, "_svalid"}, {7'd0, sv4}, 8'd1);
            chk({tag, "_done"}, {7'd0, dn4}, (i == FL4 - 1) ? 8'd1 : 8'd0);
            chk({tag, "_ready"}, {7'd0, lr4}, (i == FL4 - 1) ? 8'd1 : 8'd0);
            tick();
        end
    endtask

    task automatic check_idle4(input string tag);
        chk({tag, "_idle_sout"}, {7'd0, so4}, 8'd0);
        chk({tag, "_idle_svalid"}, {7'd0, sv4}, 8'd0);
        chk({tag, "_idle_done"}, {7'd0, dn4}, 8'd0);
        chk({tag, "_idle_ready"}, {7'd0, lr4}, 8'd1);
    endtask

    task automatic check_idle8(input string tag);
        chk({tag, "_idle8_sout"}, {7'd0, so8}, 8'd0);
        chk({tag, "_idle8_svalid"}, {7'd0, sv8}, 8'd0);
        chk({tag, "_idle8_done"}, {7'd0, dn8}, 8'd0);
        chk({tag, "_idle8_ready"}, {7'd0, lr8}, 8'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [0:0] b;
        rst  = 1'b1;
        din4 = 4'h0;
        lv4  = 1'b0;
        din8 = 8'h00;
        lv8  = 1'b0;
        tick();
        tick();
        check_idle4("reset");
        check_idle8("reset");
        rst = 1'b0;
        tick();

        // 1: single word 4'b1011, parity 1; din changes after accept.
        din4 = 4'b1011;
        lv4  = 1'b1;
        tick();
        lv4  = 1'b0;
        din4 = 4'h0;
        push_bits4(4'b1011, 1'b1);
        check_frame4("t1");
        check_idle4("t1");

        // 2: back-to-back 4'hA then 4'h5, load_valid held across the frame.
        din4 = 4'hA;
        lv4  = 1'b1;
        tick();
        din4 = 4'h5;
        push_bits4(4'hA, 1'b0);
        push_bits4(4'h5, 1'b0);
        for (int i = 0; i < 2 * FL4; i++) begin
            b = exp_q.pop_front();
            chk("t2_sout", {7'd0, so4}, {7'd0, b});
            chk("t2_svalid", {7'd0, sv4}, 8'd1);
            chk("t2_done", {7'd0, dn4}, (i == FL4 - 1 || i == 2 * FL4 - 1) ? 8'd1 : 8'd0);
            tick();
            if (i == FL4 - 1) lv4 = 1'b0;
        end
        check_idle4("t2");

        // 3: 4'h0 frame; 4'hF offered in cycles 2..3 while not ready.
        din4 = 4'h0;
        lv4  = 1'b1;
        tick();
        lv4  = 1'b0;
        for (int i = 0; i < FL4; i++) begin
            if (i == 1) begin
                din4 = 4'hF;
                lv4  = 1'b1;
            end
            if (i == 3) lv4 = 1'b0;
            chk("t3_sout", {7'd0, so4}, 8'd0);
            chk("t3_svalid", {7'd0, sv4}, 8'd1);
            tick();
        end
        lv4 = 1'b0;
        check_idle4("t3");

        // 4: reset at the edge ending cycle 2 of a 4'b1111 frame.
        din4 = 4'b1111;
        lv4  = 1'b1;
        tick();
        lv4  = 1'b0;
        chk("t4_bit0", {7'd0, so4}, 8'd1);
        tick();
        chk("t4_bit1", {7'd0, so4}, 8'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle4("t4_abort");
        tick();
        check_idle4("t4_after");
        din4 = 4'b0110;
        lv4  = 1'b1;
        tick();
        lv4  = 1'b0;
        push_bits4(4'b0110, 1'b0);
        check_frame4("t4_fresh");
        check_idle4("t4_fresh");

        // 5: 4'b0011, parity bit 0.
        din4 = 4'b0011;
        lv4  = 1'b1;
        tick();
        lv4  = 1'b0;
        push_bits4(4'b0011, 1'b0);
        check_frame4("t5");
        check_idle4("t5");

        // 6: WIDTH=8, 8'h81 (parity 0).
        din8 = 8'h81;
        lv8  = 1'b1;
        tick();
        lv8  = 1'b0;
        din8 = 8'hFF;
        for (int i = 0; i < FL8; i++) begin
            chk("t6_sout", {7'd0, so8}, (i == 0 || i == 7) ? 8'd1 : 8'd0);
            chk("t6_svalid", {7'd0, sv8}, 8'd1);
            chk("t6_done", {7'd0, dn8}, (i == FL8 - 1) ? 8'd1 : 8'd0);
            chk("t6_ready", {7'd0, lr8}, (i == FL8 - 1) ? 8'd1 : 8'd0);
            tick();
        end
        check_idle8("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/parallel_serial_tx.md
Name: parallel_serial_tx

Overview:
- Parallel-in, serial-out transmitter. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clock, LSB first, on sout.
- This bit order matches the right-shifting serial registers used elsewhere in the design, so those registers can capture the stream directly.
- sout_valid frames each transmitted bit.
- Back-to-back words stream with no idle gap.

Parameters:
- WIDTH, 4, number of data bits per word (must be ≥ 2).

Ports:
- clk  input  1  single system clock; all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- din  input  WIDTH  parallel word to transmit; sampled only on an accepted load.
- load_valid  input  1  source has a word on din.
- load_ready  output  1  transmitter can accept a word this cycle.
- sout  output  1  serial data, LSB first.
- sout_valid  output  1  sout carries a frame bit this cycle.
- done  output  1  one-cycle pulse during the last bit of a frame.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high, sampled on posedge clk.
- Reset:
  - state=IDLE, shift register=0, bit counter=0.
  - Outputs: sout=0, sout_valid=0, done=0, load_ready=1.
  - Reset takes priority over every other event.
- Internal state:
  - WIDTH-bit shift register shreg.
  - Counter cnt, width $clog2(WIDTH+1).
  - FSM with 2 states: IDLE, SHIFT.
- Frame length: FLEN = WIDTH (WIDTH+1 when parity is enabled, see Optional Feature).
- Accept condition: load_valid && load_ready at posedge clk.
  - On accept: shreg<=din, cnt<=0, state<=SHIFT.
  - When load_valid=1 and load_ready=0, nothing is sampled. The source must hold din and load_valid until accepted.
- IDLE:
  - load_ready=1, sout_valid=0, sout=0, done=0.
  - On accept, go to SHIFT.
- SHIFT:
  - sout_valid=1; sout=shreg[0] (combinational from state).
  - Each posedge: shreg<={1'b0, shreg[WIDTH-1:1]}, cnt<=cnt+1.
  - last = (cnt == FLEN-1). done=last. load_ready=last.
  - When last is true:
    - If an accept occurs on that edge: load the new word, cnt<=0, stay in SHIFT. sout_valid stays high with no gap.
    - Otherwise: state<=IDLE.
- Latency: a word accepted at edge k drives bit0 in the cycle after edge k. Bit i appears in cycle k+1+i.
- No input-data registering beyond shreg. din changes outside an accept have no effect.
- Reset mid-frame: abort the frame. Outputs return to reset values in the cycle after the reset edge. No done pulse is issued for the aborted frame.
- cnt never exceeds FLEN-1. There is no wrap-around beyond frame length.

Optional Feature:
- Macro: PARALLEL_SERIAL_TX_PARITY_EN.
- When defined:
  - On accept, also register par <= ^din (even parity).
  - FLEN = WIDTH+1. The extra cycle drives sout=par with sout_valid=1.
  - done and load_ready are asserted in the parity cycle, not in data bit WIDTH-1.
  - par resets to 0.
- When undefined:
  - No parity register. FLEN = WIDTH.
  - Behaviour exactly as above.

Test Plan:
1. WIDTH=4, accept din=4'b1011 at edge 0:
   - sout=1,1,0,1 in cycles 1..4; sout_valid=1 in cycles 1..4 only.
   - done=1 only in cycle 4; load_ready=0 in cycles 1..3.
2. Back-to-back: din=4'hA accepted at edge 0, din=4'h5 held valid and accepted at edge 4:
   - sout=0,1,0,1,1,0,1,0 over cycles 1..8, with sout_valid continuously 1.
   - done pulses in cycles 4 and 8.
3. load_valid=1 with din=4'hF in cycle 2 of a 4'h0 frame, dropped before cycle 4:
   - Not accepted; sout stays 0,0,0,0.
   - Return to IDLE after cycle 4.
4. rst=1 at the edge ending cycle 2 of a 4'b1111 frame:
   - Next cycle: sout=0, sout_valid=0, load_ready=1, done=0.
   - A fresh accept afterwards transmits normally.
5. PARITY_EN defined, din=4'b1011:
   - sout=1,1,0,1,1 in cycles 1..5; done only in cycle 5.
   - din=4'b0011 gives parity bit 0.
6. WIDTH=8, din=8'h81:
   - sout=1,0,0,0,0,0,0,1 over cycles 1..8; done in cycle 8.
   - IDLE outputs all 0 with load_ready=1 afterwards.
